// File: rtl/lynxTypes.sv
// Shared bypass-channel types and arbiter limits.
package lynxTypes;

  localparam int unsigned PID_BITS = 6;

  localparam int unsigned BPSS_ARB_MAX_REQ = 16;
  localparam int unsigned BPSS_ARB_ID_BITS = 4;

  // Host bypass request descriptor.
  typedef struct packed {
    logic [47:0]         vaddr;
    logic [27:0]         len;
    logic [PID_BITS-1:0] pid;
    logic [3:0]          dest;
    logic                ctl;
    logic                stream;
  } req_t;

  // Increment an index modulo n.
  function automatic int unsigned bpss_arb_wrap_inc(int unsigned idx, int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/bpss_arb_ord_fifo.sv
// Ordering FIFO of requester IDs; completions return in issue order so the head
// names the requester that owns the next completion.
module bpss_arb_ord_fifo #(
  parameter int unsigned IdW   = 2,
  parameter int unsigned Depth = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [IdW-1:0]           push_id_i,
  input  logic                     pop_i,
  output logic [IdW-1:0]           head_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [AddrW:0] wptr_q, wptr_d;
  logic [AddrW:0] rptr_q, rptr_d;
  logic [IdW-1:0] mem_q [Depth];
  logic           wr_en, rd_en;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]) && (wptr_q[AddrW] != rptr_q[AddrW]);
  assign count_o = wptr_q - rptr_q;
  assign head_o  = mem_q[rptr_q[AddrW-1:0]];

  assign wr_en = push_i && !full_o;
  assign rd_en = pop_i && !empty_o;

  // Pointer advance; the extra MSB is the wrap bit separating full from empty.
  always_comb begin
    wptr_d = wptr_q + {{AddrW{1'b0}}, wr_en};
    rptr_d = rptr_q + {{AddrW{1'b0}}, rd_en};
  end

  // Pointer registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wptr_q[AddrW-1:0]] <= push_id_i;
    end
  end

endmodule

// File: rtl/bpss_req_arbiter.sv
// Round-robin arbiter sharing one bypass request channel among N_REQ requesters,
// routing in-order completions back to the issuing requester.
module bpss_req_arbiter
  import lynxTypes::*;
#(
  parameter int unsigned N_REQ           = 4,
  parameter int unsigned MAX_OUTSTANDING = 16
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic [N_REQ-1:0]                  s_req_valid,
  output logic [N_REQ-1:0]                  s_req_ready,
  input  logic [N_REQ*$bits(req_t)-1:0]     s_req_data,
  output logic                              m_req_valid,
  input  logic                              m_req_ready,
  output logic [$bits(req_t)-1:0]           m_req_data,
  input  logic                              s_done_valid,
  output logic                              s_done_ready,
  input  logic [PID_BITS-1:0]               s_done_pid,
  output logic [N_REQ-1:0]                  m_done_valid,
  input  logic [N_REQ-1:0]                  m_done_ready,
  output logic [PID_BITS-1:0]               m_done_pid,
  output logic [$clog2(MAX_OUTSTANDING):0]  outstanding,
  output logic                              err_unexp_done
);

  localparam int unsigned ReqW = $bits(req_t);
  localparam int unsigned IdW  = $clog2(N_REQ);

  logic [ReqW-1:0] req_arr [N_REQ];
  logic            m_req_valid_q, m_req_valid_d;
  logic [ReqW-1:0] m_req_data_q, m_req_data_d;
  logic [IdW-1:0]  rr_ptr_q, rr_ptr_d;
  logic            err_q, err_d;

  logic            win_found;
  logic [IdW-1:0]  win_idx;
  int unsigned     cand;
  logic [IdW-1:0]  cand_idx;
  logic            loadable, grant;

  logic [IdW-1:0]  head;
  logic            fifo_empty, fifo_full;
  logic            done_hs, pop, unexp;

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign req_arr[i] = s_req_data[i*ReqW +: ReqW];
  end

  // First asserted requester searching upward from rr_ptr, wrapping at N_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      cand = 32'(rr_ptr_q) + off;
      if (cand >= N_REQ) cand = cand - N_REQ;
      cand_idx = IdW'(cand);
      if (!win_found && s_req_valid[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // Grant only on registered occupancy, so a pop frees a slot one cycle later.
  assign loadable = !m_req_valid_q || m_req_ready;
  assign grant    = aresetn && loadable && win_found && !fifo_full;

  // Combinational accept for the winner only.
  always_comb begin
    s_req_ready = '0;
    if (grant) s_req_ready[win_idx] = 1'b1;
  end

  // Completion routing to the FIFO head; an empty FIFO swallows the completion.
  always_comb begin
    m_done_valid = '0;
    s_done_ready = 1'b0;
    if (aresetn) begin
      if (fifo_empty) begin
        s_done_ready = 1'b1;
      end else begin
        m_done_valid[head] = s_done_valid;
        s_done_ready       = m_done_ready[head];
      end
    end
  end

  assign done_hs    = s_done_valid && s_done_ready;
  assign pop        = done_hs && !fifo_empty;
  assign unexp      = done_hs && fifo_empty;
  assign m_done_pid = s_done_pid;

  // Next state for the output register, round-robin pointer and sticky error.
  always_comb begin
    m_req_valid_d = m_req_valid_q;
    m_req_data_d  = m_req_data_q;
    rr_ptr_d      = rr_ptr_q;
    err_d         = err_q || unexp;
    if (grant) begin
      m_req_valid_d = 1'b1;
      m_req_data_d  = req_arr[win_idx];
      rr_ptr_d      = IdW'(bpss_arb_wrap_inc(32'(win_idx), N_REQ));
    end else if (m_req_ready) begin
      m_req_valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      m_req_valid_q <= 1'b0;
      m_req_data_q  <= '0;
      rr_ptr_q      <= '0;
      err_q         <= 1'b0;
    end else begin
      m_req_valid_q <= m_req_valid_d;
      m_req_data_q  <= m_req_data_d;
      rr_ptr_q      <= rr_ptr_d;
      err_q         <= err_d;
    end
  end

  assign m_req_valid    = m_req_valid_q;
  assign m_req_data     = m_req_data_q;
  assign err_unexp_done = err_q;

  bpss_arb_ord_fifo #(
    .IdW   (IdW),
    .Depth (MAX_OUTSTANDING)
  ) u_ord_fifo (
    .clk_i     (aclk),
    .rst_ni    (aresetn),
    .push_i    (grant),
    .push_id_i (win_idx),
    .pop_i     (pop),
    .head_o    (head),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full),
    .count_o   (outstanding)
  );

endmodule

// File: tb/tb_bpss_req_arbiter.sv
// Scoreboard bench: stimulus pushes expected requests/completions, a negedge
// monitor pops and compares on every handshake.
module tb_bpss_req_arbiter;
  import lynxTypes::*;

  localparam int unsigned NReq   = 4;
  localparam int unsigned MaxOut = 4;
  localparam int unsigned ReqW   = $bits(req_t);

  typedef struct {
    int          id;
    logic [5:0]  pid;
  } done_t;

  logic                 aclk = 1'b0;
  logic                 aresetn = 1'b0;
  logic [NReq-1:0]      s_req_valid = '0;
  logic [NReq-1:0]      s_req_ready;
  logic [NReq*ReqW-1:0] s_req_data;
  logic                 m_req_valid;
  logic                 m_req_ready = 1'b0;
  logic [ReqW-1:0]      m_req_data;
  logic                 s_done_valid = 1'b0;
  logic                 s_done_ready;
  logic [PID_BITS-1:0]  s_done_pid = '0;
  logic [NReq-1:0]      m_done_valid;
  logic [NReq-1:0]      m_done_ready = '1;
  logic [PID_BITS-1:0]  m_done_pid;
  logic [2:0]           outstanding;
  logic                 err_unexp_done;

  logic [ReqW-1:0] slice [NReq];
  logic [ReqW-1:0] exp_req_q [$];
  done_t           exp_done_q [$];
  int              errors = 0;
  int              checks = 0;
  int              req_hs = 0;

  always #5 aclk = ~aclk;

  for (genvar i = 0; i < NReq; i++) begin : g_pack
    assign s_req_data[i*ReqW +: ReqW] = slice[i];
  end

  bpss_req_arbiter #(
    .N_REQ           (NReq),
    .MAX_OUTSTANDING (MaxOut)
  ) dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .s_req_valid    (s_req_valid),
    .s_req_ready    (s_req_ready),
    .s_req_data     (s_req_data),
    .m_req_valid    (m_req_valid),
    .m_req_ready    (m_req_ready),
    .m_req_data     (m_req_data),
    .s_done_valid   (s_done_valid),
    .s_done_ready   (s_done_ready),
    .s_done_pid     (s_done_pid),
    .m_done_valid   (m_done_valid),
    .m_done_ready   (m_done_ready),
    .m_done_pid     (m_done_pid),
    .outstanding    (outstanding),
    .err_unexp_done (err_unexp_done)
  );

  function automatic logic [ReqW-1:0] mk(int i, int tag);
    return {8'(tag), 8'(i), 72'h5A3C0F123456789ABC};
  endfunction

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic at_neg;
    @(negedge aclk);
  endtask

  task automatic push_done(input int id, input logic [5:0] pid);
    done_t e;
    e.id  = id;
    e.pid = pid;
    exp_done_q.push_back(e);
  endtask

  // Monitor: compare every request and routed-completion handshake.
  always @(negedge aclk) begin
    if (aresetn) begin
      if (m_req_valid && m_req_ready) begin
        req_hs++;
        if (exp_req_q.size() == 0) chk("m_req_unexpected", m_req_data, '0);
        else chk("m_req_data", m_req_data, exp_req_q.pop_front());
      end
      if (s_done_valid && s_done_ready && (m_done_valid != '0)) begin
        if (exp_done_q.size() == 0) begin
          chk("m_done_unexpected", m_done_valid, '0);
        end else begin
          done_t e;
          e = exp_done_q.pop_front();
          chk("m_done_valid", m_done_valid, 96'(1 << e.id));
          chk("m_done_pid", m_done_pid, e.pid);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ReqW-1:0] d2;
    int hs0;
    for (int i = 0; i < NReq; i++) slice[i] = mk(i, 16 + i);

    // Reset: combinational outputs gated even with active inputs.
    s_req_valid  = 4'hF;
    s_done_valid = 1'b1;
    tick;
    tick;
    at_neg;
    chk("rst_s_req_ready", s_req_ready, 0);
    chk("rst_s_done_ready", s_done_ready, 0);
    chk("rst_m_done_valid", m_done_valid, 0);
    chk("rst_m_req_valid", m_req_valid, 0);
    chk("rst_m_req_data", m_req_data, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_err", err_unexp_done, 0);

    // Round robin 0,1,2,3 back to back, then FIFO full.
    tick;
    aresetn      = 1'b1;
    s_done_valid = 1'b0;
    s_req_valid  = 4'hF;
    m_req_ready  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_req_q.push_back(slice[i]);
      at_neg;
      chk("rr_grant", s_req_ready, 96'(1 << i));
      tick;
    end
    at_neg;
    chk("full_outstanding", outstanding, 4);
    chk("full_no_ready", s_req_ready, 0);
    tick;
    at_neg;
    chk("full_drained", m_req_valid, 0);
    chk("full_still_blocked", s_req_ready, 0);
    chk("rr_handshakes", req_hs, 4);

    // One completion frees a slot; grant follows one cycle after the pop.
    tick;
    s_done_valid = 1'b1;
    s_done_pid   = 6'd9;
    push_done(0, 6'd9);
    at_neg;
    chk("pop_cycle_done_ready", s_done_ready, 1);
    chk("pop_cycle_no_grant", s_req_ready, 0);
    tick;
    s_done_valid = 1'b0;
    exp_req_q.push_back(slice[0]);
    at_neg;
    chk("after_pop_grant", s_req_ready, 4'b0001);
    chk("after_pop_outstanding", outstanding, 3);
    tick;
    s_req_valid = '0;
    at_neg;
    chk("refill_outstanding", outstanding, 4);

    // Drain 1,2 freely, then stall requester 3, then 0.
    tick;
    s_done_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      s_done_pid = 6'(10 + k);
      push_done(k + 1, 6'(10 + k));
      tick;
    end
    m_done_ready = 4'b0111;
    s_done_pid   = 6'd12;
    for (int k = 0; k < 3; k++) begin
      at_neg;
      chk("stall_done_ready", s_done_ready, 0);
      chk("stall_m_done_valid", m_done_valid, 4'b1000);
      tick;
    end
    m_done_ready = 4'hF;
    push_done(3, 6'd12);
    tick;
    s_done_pid = 6'd13;
    push_done(0, 6'd13);
    tick;
    s_done_valid = 1'b0;
    at_neg;
    chk("drain_outstanding", outstanding, 0);

    // In-order routing: grants 1,3,1 and completions 5,6,7.
    tick;
    s_req_valid = 4'b0010; exp_req_q.push_back(slice[1]); tick;
    s_req_valid = 4'b1000; exp_req_q.push_back(slice[3]); tick;
    s_req_valid = 4'b0010; exp_req_q.push_back(slice[1]); tick;
    s_req_valid  = '0;
    s_done_valid = 1'b1;
    s_done_pid = 6'd5; push_done(1, 6'd5); tick;
    s_done_pid = 6'd6; push_done(3, 6'd6); tick;
    s_done_pid = 6'd7; push_done(1, 6'd7); tick;
    s_done_valid = 1'b0;
    at_neg;
    chk("route_outstanding", outstanding, 0);

    // Request backpressure: data held for 5 cycles while the source changes.
    tick;
    s_req_valid = 4'b0100;
    m_req_ready = 1'b0;
    d2 = slice[2];
    exp_req_q.push_back(d2);
    tick;
    s_req_valid = '0;
    slice[2]    = mk(2, 8'h77);
    hs0         = req_hs;
    for (int k = 0; k < 5; k++) begin
      at_neg;
      chk("bp_valid", m_req_valid, 1);
      chk("bp_data", m_req_data, d2);
      tick;
    end
    m_req_ready = 1'b1;
    tick;
    at_neg;
    chk("bp_released", m_req_valid, 0);
    chk("bp_outstanding", outstanding, 1);
    tick;
    at_neg;
    chk("bp_one_handshake", req_hs - hs0, 1);
    tick;
    s_done_valid = 1'b1;
    s_done_pid   = 6'd20;
    push_done(2, 6'd20);
    tick;

    // Unexpected completion with nothing outstanding.
    s_done_pid = 6'd33;
    at_neg;
    chk("unexp_done_ready", s_done_ready, 1);
    chk("unexp_no_route", m_done_valid, 0);
    chk("unexp_err_before", err_unexp_done, 0);
    tick;
    s_done_valid = 1'b0;
    at_neg;
    chk("unexp_err_set", err_unexp_done, 1);
    chk("unexp_outstanding", outstanding, 0);

    // Reset with 3 outstanding and one request held in the output register.
    tick;
    s_req_valid = 4'b0001; exp_req_q.push_back(slice[0]); tick;
    s_req_valid = 4'b0010; exp_req_q.push_back(slice[1]); tick;
    s_req_valid = 4'b0100; exp_req_q.push_back(slice[2]); tick;
    s_req_valid = '0;
    m_req_ready = 1'b0;
    at_neg;
    chk("pre_rst_outstanding", outstanding, 3);
    chk("pre_rst_m_req_valid", m_req_valid, 1);
    tick;
    aresetn      = 1'b0;
    s_req_valid  = 4'hF;
    s_done_valid = 1'b1;
    s_done_pid   = 6'd40;
    at_neg;
    chk("mid_rst_s_req_ready", s_req_ready, 0);
    chk("mid_rst_s_done_ready", s_done_ready, 0);
    chk("mid_rst_m_done_valid", m_done_valid, 0);
    tick;
    exp_req_q.delete();
    at_neg;
    chk("mid_rst_m_req_valid", m_req_valid, 0);
    chk("mid_rst_m_req_data", m_req_data, 0);
    chk("mid_rst_outstanding", outstanding, 0);
    chk("mid_rst_err", err_unexp_done, 0);
    tick;
    aresetn     = 1'b1;
    s_req_valid = '0;
    at_neg;
    chk("stale_done_ready", s_done_ready, 1);
    chk("stale_no_route", m_done_valid, 0);
    tick;
    s_done_valid = 1'b0;
    at_neg;
    chk("stale_err_set", err_unexp_done, 1);

    chk("req_queue_empty", exp_req_q.size(), 0);
    chk("done_queue_empty", exp_done_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bpss_req_arbiter.md
# bpss_req_arbiter

Round-robin arbiter that shares one host bypass request channel (`bpss_rd_req` or `bpss_wr_req`) among `N_REQ` user-logic requesters inside `design_user_logic`. It routes each returning `bpss_*_done` completion back to the requester that issued the matching request. Completions on a bypass channel return in issue order, so an ordering FIFO of requester IDs performs the routing. One instance serves the read direction and one serves the write direction.

## Interface

Parameters:

- `N_REQ`, default 4: number of requesters; range 2..16.
- `MAX_OUTSTANDING`, default 16: depth of the ordering FIFO; power of 2, range 2..64.

Ports:

- `aclk`  in  1  clock.
- `aresetn`  in  1  reset, synchronous, active-low.
- `s_req_valid`  in  N_REQ  per-requester request valid.
- `s_req_ready`  out  N_REQ  per-requester accept; one-hot or zero.
- `s_req_data`  in  N_REQ*$bits(req_t)  requester i occupies slice i.
- `m_req_valid`  out  1  request to the host bypass channel.
- `m_req_ready`  in  1  host bypass channel accept.
- `m_req_data`  out  $bits(req_t)  registered winning request.
- `s_done_valid`  in  1  completion from host.
- `s_done_ready`  out  1  completion accept.
- `s_done_pid`  in  PID_BITS  completion PID.
- `m_done_valid`  out  N_REQ  routed completion; one-hot or zero.
- `m_done_ready`  in  N_REQ  per-requester completion accept.
- `m_done_pid`  out  PID_BITS  `s_done_pid` passed through.
- `outstanding`  out  $clog2(MAX_OUTSTANDING)+1  count of accepted but uncompleted requests.
- `err_unexp_done`  out  1  sticky flag: a completion arrived while `outstanding`==0.

## Operation

Request path:

- The output register (`m_req_valid`/`m_req_data`) is *loadable* when it is empty, or when it is full and `m_req_ready`=1 in that cycle.
- A grant occurs when the register is loadable, some `s_req_valid[i]`=1, and `outstanding` < `MAX_OUTSTANDING`.
- Winner: the first asserted requester found searching upward from `rr_ptr`, modulo `N_REQ`.
- On a grant:
  - `s_req_ready[winner]`=1 combinationally;
  - the register loads `s_req_data[winner]`;
  - the winner ID is pushed into the ordering FIFO;
  - `rr_ptr` becomes winner+1 mod `N_REQ`.
- Without a grant, `rr_ptr` holds.
- A requester that has been granted may keep `valid` high; it is re-arbitrated from the new `rr_ptr`.

Completion path:

- When the FIFO is non-empty, head = oldest ID.
- `m_done_valid[head]` = `s_done_valid`.
- `s_done_ready` = `m_done_ready[head]`.
- The FIFO pops on the `s_done` handshake.
- Completions are never buffered; backpressure from requester `head` stalls `s_done`.

Empty FIFO:

- `s_done_ready`=1, so the completion is consumed and dropped.
- All `m_done_valid`=0.
- `err_unexp_done` sets and is cleared only by reset.

Occupancy:

- `outstanding` = FIFO occupancy.
- Push and pop in the same cycle leave it unchanged.
- Full: no grants, all `s_req_ready`=0; the completion path keeps working.

## Timing

Reset:

- `aresetn` is sampled on the `aclk` rising edge.
- Reset values: `m_req_valid`=0, `m_req_data`=0, FIFO empty, `outstanding`=0, `rr_ptr`=0, `err_unexp_done`=0.
- Combinational outputs fall to 0 while reset is asserted: `s_req_ready`, `s_done_ready`, `m_done_valid`.

Latency and throughput:

- Request latency is 1 cycle: the grant edge produces `m_req_valid` on the next cycle.
- Sustained throughput is 1 request per cycle while `m_req_ready`=1.
- `m_req_data` is stable while `m_req_valid`=1 and `m_req_ready`=0.
- Completion latency is 0 cycles (combinational pass-through).

Full-FIFO boundary:

- A pop in cycle t lowers `outstanding` at t+1.
- A grant may occur at t+1, not at t; the grant decision uses registered `outstanding` only.

Reset mid-operation:

- Any in-flight `m_req` is dropped and the FIFO contents are discarded.
- Later completions for dropped requests raise `err_unexp_done`.

## Structure

- The constants `BPSS_ARB_MAX_REQ`=16 and `BPSS_ARB_ID_BITS`=4 belong in `lynxTypes`.
- `req_t` and `PID_BITS` are the existing `lynxTypes` definitions.
- One sub-module, `bpss_arb_ord_fifo`:
  - synchronous FIFO of `$clog2(N_REQ)`-bit IDs, depth `MAX_OUTSTANDING`;
  - registered read/write pointers with a wrap bit;
  - count output drives `outstanding`.
- Arbiter, output register and routing logic live in the top module.

## Test plan

- **Round-robin fairness.** `N_REQ`=4, all four valid continuously, `m_req_ready`=1 → grant order 0,1,2,3,0,…; one `m_req` per cycle; each `m_req_data` matches the granted slice.
- **Backpressure.** Requester 2 valid; `m_req_ready`=0 for 5 cycles, then 1 → `m_req_data` holds requester 2's data for 5 cycles; exactly one handshake; `outstanding`=1.
- **Full FIFO.** `MAX_OUTSTANDING`=4; 4 requests accepted with no completions → `s_req_ready`=0 and `outstanding`=4. One completion → next grant exactly 1 cycle after the pop.
- **In-order routing.** Grants 1,3,1; three completions with PIDs 5,6,7 → `m_done_valid` one-hot to 1,3,1 in order; `m_done_pid`=5,6,7.
- **Completion backpressure.** `m_done_ready[3]`=0 while requester 3 is head → `s_done_ready`=0; completion stalls until ready; no other requester sees `m_done_valid`.
- **Error and reset.** Completion with `outstanding`=0 → consumed, `err_unexp_done`=1. Reset with 3 outstanding → all outputs at reset values; `err_unexp_done` cleared.
